// File: rtl/mod_updown_counter.sv
// Modulo up/down counter over 0..MAX_COUNT with parallel load and wrap or saturate at the limits.
// Registered carry/borrow pulses let instances cascade, one cycle of latency per stage.
module mod_updown_counter #(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 7,
  parameter bit SATURATE  = 1'b0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             incr,
  input  logic             decr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             at_max,
  output logic             at_zero,
  output logic             carry,
  output logic             borrow
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 1..16");
  end
  if (MAX_COUNT < 1 || MAX_COUNT > ((1 << WIDTH) - 1)) begin : g_bad_max
    $error("mod_updown_counter: MAX_COUNT must be in 1..2^WIDTH-1");
  end
  if (RESET_VAL < 0 || RESET_VAL > MAX_COUNT) begin : g_bad_rst
    $error("mod_updown_counter: RESET_VAL must be in 0..MAX_COUNT");
  end

  localparam logic [WIDTH:0]   LP_MAX   = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] LP_MAX_W = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] LP_RST   = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_borrow;

  logic [WIDTH:0]   w_out_ext;
  logic [WIDTH:0]   w_next_ext;
  logic [WIDTH-1:0] w_next;
  logic             w_carry;
  logic             w_borrow;

  assign w_out_ext = {1'b0, r_out};

  // Next value is formed one bit wider; the final clamp also handles oversized loads.
  always_comb begin
    w_next_ext = w_out_ext;
    w_carry    = 1'b0;
    w_borrow   = 1'b0;
    if (load) begin
      w_next_ext = {1'b0, load_val};
    end else if (incr && !decr) begin
      if (w_out_ext == LP_MAX) begin
        w_next_ext = SATURATE ? LP_MAX : '0;
        w_carry    = 1'b1;
      end else begin
        w_next_ext = w_out_ext + (WIDTH+1)'(1);
      end
    end else if (decr && !incr) begin
      if (r_out == '0) begin
        w_next_ext = SATURATE ? '0 : LP_MAX;
        w_borrow   = 1'b1;
      end else begin
        w_next_ext = w_out_ext - (WIDTH+1)'(1);
      end
    end
    w_next = (w_next_ext > LP_MAX) ? LP_MAX_W : w_next_ext[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_out    <= LP_RST;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_out    <= w_next;
      r_carry  <= w_carry;
      r_borrow <= w_borrow;
    end
  end

  assign out     = r_out;
  assign carry   = r_carry;
  assign borrow  = r_borrow;
  assign at_max  = (w_out_ext == LP_MAX);
  assign at_zero = (r_out == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: several counter configurations share one stimulus bus; a vector table
// selects which instance each row checks, followed by a hand-written cascade sequence.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       incr = 1'b0;
  logic       decr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] lv = 4'd0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // sel 0: W3 M7 wrap, 1: W3 M5 wrap, 2: W3 M7 sat, 3: W4 M5 wrap, 4: W3 M7 wrap RESET_VAL=2
  logic [2:0] out_a, out_b, out_c, out_e;
  logic [3:0] out_d, out_lo, out_hi;
  logic am_a, az_a, c_a, b_a, am_b, az_b, c_b, b_b, am_c, az_c, c_c, b_c;
  logic am_d, az_d, c_d, b_d, am_e, az_e, c_e, b_e;
  logic am_lo, az_lo, c_lo, b_lo, am_hi, az_hi, c_hi, b_hi;

  mod_updown_counter #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(1'b0), .RESET_VAL(0)) u_a (
    .clk(clk), .Reset(Reset), .incr(incr), .decr(decr), .load(load), .load_val(lv[2:0]),
    .out(out_a), .at_max(am_a), .at_zero(az_a), .carry(c_a), .borrow(b_a));
  mod_updown_counter #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1'b0), .RESET_VAL(0)) u_b (
    .clk(clk), .Reset(Reset), .incr(incr), .decr(decr), .load(load), .load_val(lv[2:0]),
    .out(out_b), .at_max(am_b), .at_zero(az_b), .carry(c_b), .borrow(b_b));
  mod_updown_counter #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(1'b1), .RESET_VAL(0)) u_c (
    .clk(clk), .Reset(Reset), .incr(incr), .decr(decr), .load(load), .load_val(lv[2:0]),
    .out(out_c), .at_max(am_c), .at_zero(az_c), .carry(c_c), .borrow(b_c));
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(5), .SATURATE(1'b0), .RESET_VAL(0)) u_d (
    .clk(clk), .Reset(Reset), .incr(incr), .decr(decr), .load(load), .load_val(lv),
    .out(out_d), .at_max(am_d), .at_zero(az_d), .carry(c_d), .borrow(b_d));
  mod_updown_counter #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(1'b0), .RESET_VAL(2)) u_e (
    .clk(clk), .Reset(Reset), .incr(incr), .decr(decr), .load(load), .load_val(lv[2:0]),
    .out(out_e), .at_max(am_e), .at_zero(az_e), .carry(c_e), .borrow(b_e));
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0), .RESET_VAL(0)) u_lo (
    .clk(clk), .Reset(Reset), .incr(incr), .decr(1'b0), .load(1'b0), .load_val(4'd0),
    .out(out_lo), .at_max(am_lo), .at_zero(az_lo), .carry(c_lo), .borrow(b_lo));
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0), .RESET_VAL(0)) u_hi (
    .clk(clk), .Reset(Reset), .incr(c_lo), .decr(1'b0), .load(1'b0), .load_val(4'd0),
    .out(out_hi), .at_max(am_hi), .at_zero(az_hi), .carry(c_hi), .borrow(b_hi));

  typedef struct {
    int         sel;
    logic       rst;
    logic       inc;
    logic       dec;
    logic       ld;
    logic [3:0] lv;
    int         eo;
    logic       ec;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int sel, logic rst, logic inc, logic dec, logic ld,
                              logic [3:0] v, int eo, logic ec, logic eb);
    vec_t r;
    r.sel = sel; r.rst = rst; r.inc = inc; r.dec = dec; r.ld = ld;
    r.lv = v; r.eo = eo; r.ec = ec; r.eb = eb;
    vecs.push_back(r);
  endfunction

  function automatic int maxof(int sel);
    case (sel)
      1, 3:    return 5;
      default: return 7;
    endcase
  endfunction

  task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic get(int sel, output logic [3:0] o, output logic c, output logic b,
                     output logic am, output logic az);
    case (sel)
      0:       begin o = {1'b0, out_a}; c = c_a; b = b_a; am = am_a; az = az_a; end
      1:       begin o = {1'b0, out_b}; c = c_b; b = b_b; am = am_b; az = az_b; end
      2:       begin o = {1'b0, out_c}; c = c_c; b = b_c; am = am_c; az = az_c; end
      3:       begin o = out_d;         c = c_d; b = b_d; am = am_d; az = az_d; end
      default: begin o = {1'b0, out_e}; c = c_e; b = b_e; am = am_e; az = az_e; end
    endcase
  endtask

  task automatic drive(logic rst, logic inc, logic dec, logic ld, logic [3:0] v);
    Reset = rst; incr = inc; decr = dec; load = ld; lv = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] o;
    logic c, b, am, az;

    // Default config: reset, incr x10 with wrap, priority load over incr, decr through zero.
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) add(0, 0, 1, 0, 0, 0, i % 8, (i == 8), 0);
    add(0, 0, 1, 0, 1, 3, 3, 0, 0);
    add(0, 0, 0, 1, 0, 0, 2, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 7, 0, 1);
    add(0, 0, 0, 0, 0, 0, 7, 0, 0);
    // MAX=5 wrap: down through zero then up through MAX.
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 5, 0, 1);
    add(1, 0, 0, 1, 0, 0, 4, 0, 0);
    add(1, 0, 0, 1, 0, 0, 3, 0, 0);
    add(1, 0, 1, 0, 0, 0, 4, 0, 0);
    add(1, 0, 1, 0, 0, 0, 5, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 1, 0);
    // Saturate: load 6, incr sticks at 7 with carry each attempt, decr sticks at 0.
    add(2, 1, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 0, 0, 1, 6, 6, 0, 0);
    add(2, 0, 1, 0, 0, 0, 7, 0, 0);
    add(2, 0, 1, 0, 0, 0, 7, 1, 0);
    add(2, 0, 1, 0, 0, 0, 7, 1, 0);
    for (int i = 1; i <= 8; i++) add(2, 0, 0, 1, 0, 0, (i < 8) ? 7 - i : 0, 0, (i == 8));
    // W4 M5: oversized load clamps, incr+decr together holds.
    add(3, 1, 0, 0, 0, 0, 0, 0, 0);
    add(3, 0, 0, 0, 1, 9, 5, 0, 0);
    add(3, 0, 1, 1, 0, 0, 5, 0, 0);
    // RESET_VAL=2: reset wins over load and incr mid-count.
    add(4, 1, 0, 0, 0, 0, 2, 0, 0);
    for (int i = 3; i <= 6; i++) add(4, 0, 1, 0, 0, 0, i, 0, 0);
    add(4, 1, 1, 0, 1, 5, 2, 0, 0);
    add(4, 0, 1, 0, 0, 0, 3, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].inc, vecs[i].dec, vecs[i].ld, vecs[i].lv);
      get(vecs[i].sel, o, c, b, am, az);
      chk("out", i, 16'(o), 16'(vecs[i].eo));
      chk("carry", i, 16'(c), 16'(vecs[i].ec));
      chk("borrow", i, 16'(b), 16'(vecs[i].eb));
      chk("at_max", i, 16'(am), 16'(vecs[i].eo == maxof(vecs[i].sel)));
      chk("at_zero", i, 16'(az), 16'(vecs[i].eo == 0));
    end

    // Cascade of two decimal digits: 25 increments should read {2,5}.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("casc_rst_lo", 0, 16'(out_lo), 16'd0);
    chk("casc_rst_hi", 0, 16'(out_hi), 16'd0);
    for (int i = 1; i <= 25; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      if (i == 10) begin
        chk("casc_wrap_lo", i, 16'(out_lo), 16'd0);
        chk("casc_wrap_carry", i, 16'(c_lo), 16'd1);
        chk("casc_wrap_hi", i, 16'(out_hi), 16'd0);
      end
      if (i == 11) begin
        chk("casc_next_hi", i, 16'(out_hi), 16'd1);
        chk("casc_next_carry", i, 16'(c_lo), 16'd0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("casc_final_lo", 25, 16'(out_lo), 16'd5);
    chk("casc_final_hi", 25, 16'(out_hi), 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised modulo up/down counter, successor to the 3-bit score/round up-counter used by the game logic. Counts up, counts down, and parallel-loads within 0..MAX_COUNT. Selectable wrap or saturate at the limits. Registered carry/borrow pulses let several instances cascade, e.g. for a multi-digit score or a round-win tally feeding the HEX display logic.

Parameters:
WIDTH, 3, counter width in bits; legal range 1..16.
MAX_COUNT, 7, terminal value; must satisfy 1 <= MAX_COUNT <= 2^WIDTH-1, otherwise elaboration error via $error.
SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits.
RESET_VAL, 0, value loaded on reset; must be <= MAX_COUNT.

Ports:
clk  input  1  system clock; all state updates on posedge.
Reset  input  1  synchronous, active-high reset.
incr  input  1  count up by one this cycle.
decr  input  1  count down by one this cycle.
load  input  1  parallel-load load_val this cycle.
load_val  input  WIDTH  value for load.
out  output  WIDTH  current count, registered.
at_max  output  1  combinational; out == MAX_COUNT.
at_zero  output  1  combinational; out == 0.
carry  output  1  registered one-cycle pulse for an up-limit event.
borrow  output  1  registered one-cycle pulse for a down-limit event.

Behaviour:
- One clock domain; all registers update on posedge clk. Reset is synchronous and active-high.
- Reset: out <= RESET_VAL; carry <= 0; borrow <= 0. Reset overrides every other input in the same cycle. Asserting Reset mid-count discards the count on the next edge.
- Priority per edge: Reset > load > incr/decr.
- Load: out <= min(load_val, MAX_COUNT). Values above MAX_COUNT clamp to MAX_COUNT. carry and borrow are 0 on a load cycle.
- incr=1, decr=1 together (no load): out holds; carry and borrow are 0.
- incr only, out < MAX_COUNT: out <= out+1; carry <= 0.
- incr only, out == MAX_COUNT:
  - SATURATE=0: out <= 0; carry <= 1.
  - SATURATE=1: out holds at MAX_COUNT; carry <= 1 (signals an attempted overflow).
- decr only, out > 0: out <= out-1; borrow <= 0.
- decr only, out == 0:
  - SATURATE=0: out <= MAX_COUNT; borrow <= 1.
  - SATURATE=1: out holds at 0; borrow <= 1.
- No action (incr=decr=load=0): out holds; carry and borrow are 0.
- carry and borrow are high for exactly the one cycle after the triggering edge, i.e. they update together with out. With incr held high continuously, carry pulses once every MAX_COUNT+1 cycles in wrap mode and every cycle in saturate mode while at the limit.
- Arithmetic is internally WIDTH+1 bits; out never leaves 0..MAX_COUNT. When MAX_COUNT = 2^WIDTH-1, natural rollover must match the explicit wrap.
- Cascading: the upper stage's incr connects to the lower stage's carry, giving one cycle of latency per stage.
- X on incr, decr or load while Reset=1 must not propagate to out.

Test Plan:
- Defaults (WIDTH=3, MAX=7, wrap): Reset 1 cycle, then incr=1 for 10 cycles -> out 1..7, 0, 1, 2; carry=1 only in the cycle out==0; at_max=1 only while out==7.
- MAX_COUNT=5, wrap: from 0 apply decr=1 for 3 cycles -> out 5, 4, 3; borrow=1 only with the first out==5. Then incr 3 cycles -> 4, 5, 0 with carry at 0.
- SATURATE=1, MAX=7: load 6, then incr 3 cycles -> out 7, 7, 7; carry=0, 1, 1. Then decr 8 cycles -> 6..0, 0; borrow=1 only on the final cycle.
- Priority: load_val=3 with load=1, incr=1 -> out=3, carry=0. Load 9 with WIDTH=4, MAX=5 -> out=5. incr=decr=1 at out=5 -> out holds 5, no pulse.
- Reset mid-operation: RESET_VAL=2; count to 6, then assert Reset together with incr=1 and load=1 -> out=2, carry=0, borrow=0 next cycle. Deassert Reset -> counting resumes from 2.
- Cascade: two WIDTH=4, MAX=9 instances, upper incr tied to lower carry, 25 incr pulses -> {upper, lower} = {2, 5}; upper changes one cycle after lower wraps.
